mem_responder: RTL

//   Memory-side responder for the multicycle core's unified instruction/data port.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder - word-array memory responder with programmable read/write wait states
// One request in flight at a time; valid/ready request and response channels.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        access;
  logic        access_err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign access_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign idx = addr_q[AW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture; only meaningful once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) cnt <= req_we ? 4'(WR_LAT) : 4'(RD_LAT);
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_err   <= access_err;
            resp_rdata <= (!we_q && !access_err) ? mem[idx] : 32'd0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so a write caught in BUSY is never committed.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
